// File: rtl/prog_loader.sv
// prog_loader: fills program memory from a framed serial byte stream
// (SYNC, LEN_HI, LEN_LO, payload[, checksum]) and holds the CPU in reset
// until a complete image has been written.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing
// 8-bit additive checksum byte that must match before the CPU is released.
module prog_loader #(
    parameter int unsigned SIZE      = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              write,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [7:0]        writevalue,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned LEN_W = 16;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;
`endif

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    logic             accept;
    logic [LEN_W-1:0] len_full;
    logic             is_sync;

    // Handshake qualifier and the full length as it completes in LEN_LO
    always_comb begin
        accept   = rx_valid && rx_ready;
        len_full = {len[LEN_W-1:8], rx_data};
        is_sync  = (rx_data == SYNC);
    end

    // Frame parser, progmem write port and CPU reset control
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
            rx_ready   <= 1'b0;
            write      <= 1'b0;
            writeaddr  <= '0;
            writevalue <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            rx_ready <= 1'b1;
            write    <= 1'b0;
            // Release the CPU one edge after DONE is entered; a SYNC below overrides
            if (state == S_DONE) begin
                cpu_rst <= 1'b0;
            end
            if (accept) begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (is_sync) begin
                            state     <= S_LEN_HI;
                            cpu_rst   <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end
                    end
                    S_LEN_HI: begin
                        len[LEN_W-1:8] <= rx_data;
                        state          <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len[7:0] <= rx_data;
                        if (len_full == '0 || 32'(len_full) > SIZE) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end else begin
                            state <= S_DATA;
                            idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end
                    end
                    S_DATA: begin
                        write      <= 1'b1;
                        writeaddr  <= ADDR_W'(BASE_ADDR + 32'(idx));
                        writevalue <= rx_data;
                        idx        <= idx + LEN_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum       <= csum + rx_data;
                        if (idx == len - LEN_W'(1)) begin
                            state <= S_CSUM;
                        end
`else
                        if (idx == len - LEN_W'(1)) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end
`endif
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_data == csum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a cycle table of {rx inputs, expected
// outputs} plus hand-written reset sequences. Adapts to PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       write;
    logic [7:0] writeaddr;
    logic [7:0] writevalue;
    logic       cpu_rst;
    logic       load_done;
    logic       load_err;

    int tests;
    int fails;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit DN = 1'b0;
`else
    localparam bit DN = 1'b1;
`endif

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       w;
        logic [7:0] a;
        logic [7:0] val;
        logic       cr;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .write     (write),
        .writeaddr (writeaddr),
        .writevalue(writevalue),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void r(input logic v, input logic [7:0] d, input logic w,
                              input logic [7:0] a, input logic [7:0] val,
                              input logic cr, input logic dn, input logic er);
        vecs.push_back('{v, d, w, a, val, cr, dn, er});
    endfunction

    // idle cycle (no byte offered)
    function automatic void g(input logic cr, input logic dn, input logic er);
        r(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, cr, dn, er);
    endfunction

    // accepted byte that must not write
    function automatic void b(input logic [7:0] d, input logic cr, input logic dn, input logic er);
        r(1'b1, d, 1'b0, 8'h00, 8'h00, cr, dn, er);
    endfunction

    // accepted payload byte: write (a, d) expected
    function automatic void p(input logic [7:0] d, input logic [7:0] a, input logic dn);
        r(1'b1, d, 1'b1, a, d, 1'b1, dn, 1'b0);
    endfunction

    function automatic void build();
        // garbage, then a gapped frame A5 00 03 10 20 30
        b(8'h00, 1, 0, 0); b(8'hFF, 1, 0, 0); b(8'h12, 1, 0, 0); g(1, 0, 0);
        b(8'hA5, 1, 0, 0); g(1, 0, 0); b(8'h00, 1, 0, 0); b(8'h03, 1, 0, 0);
        p(8'h10, 8'd0, 0); g(1, 0, 0); g(1, 0, 0);
        p(8'h20, 8'd1, 0); g(1, 0, 0); g(1, 0, 0); g(1, 0, 0);
        p(8'h30, 8'd2, DN);
`ifdef PROG_LOADER_CHECKSUM_EN
        b(8'h60, 1, 1, 0);
`endif
        g(0, 1, 0);
        // reload, gap-free: cpu_rst reasserts on the SYNC edge
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h03, 1, 0, 0);
        p(8'h10, 8'd0, 0); p(8'h20, 8'd1, 0); p(8'h30, 8'd2, DN);
`ifdef PROG_LOADER_CHECKSUM_EN
        b(8'h60, 1, 1, 0);
`endif
        g(0, 1, 0); g(0, 1, 0);
        // zero length
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h00, 1, 0, 1); g(1, 0, 1);
        // 257 > SIZE
        b(8'hA5, 1, 0, 0); b(8'h01, 1, 0, 0); b(8'h01, 1, 0, 1); g(1, 0, 1);
        // recovery with a single byte image
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h01, 1, 0, 0);
        p(8'h7F, 8'd0, DN);
`ifdef PROG_LOADER_CHECKSUM_EN
        b(8'h7F, 1, 1, 0);
`endif
        g(0, 1, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        // good checksum
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h02, 1, 0, 0);
        p(8'h01, 8'd0, 0); p(8'h02, 8'd1, 0); b(8'h03, 1, 1, 0); g(0, 1, 0);
        // bad checksum: two writes only, cpu stays in reset
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h02, 1, 0, 0);
        p(8'h01, 8'd0, 0); p(8'h02, 8'd1, 0); b(8'h04, 1, 0, 1); g(1, 0, 1); g(1, 0, 1);
`endif
    endfunction

    task automatic send(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
    endtask

    initial begin
        int nwr;
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        build();

        // reset held for two edges
        @(negedge clk);
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(writeaddr), 32'd0);
        chk("rst_value", 32'(writevalue), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_rx_ready", 32'(rx_ready), 32'd1);
        chk("rel_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rel_write", 32'(write), 32'd0);

        // table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            @(negedge clk);
            chk($sformatf("row%0d_write", i), 32'(write), 32'(vecs[i].w));
            chk($sformatf("row%0d_cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].cr));
            chk($sformatf("row%0d_done", i), 32'(load_done), 32'(vecs[i].dn));
            chk($sformatf("row%0d_err", i), 32'(load_err), 32'(vecs[i].er));
            chk($sformatf("row%0d_rx_ready", i), 32'(rx_ready), 32'd1);
            if (vecs[i].w) begin
                chk($sformatf("row%0d_addr", i), 32'(writeaddr), 32'(vecs[i].a));
                chk($sformatf("row%0d_value", i), 32'(writevalue), 32'(vecs[i].val));
            end
        end
        rx_valid = 1'b0;
        @(negedge clk);

        // reset in DATA after one of three bytes
        send(8'hA5);
        send(8'h00);
        send(8'h03);
        send(8'h11);
        chk("mid_first_write", 32'(write), 32'd1);
        chk("mid_first_addr", 32'(writeaddr), 32'd0);
        chk("mid_first_value", 32'(writevalue), 32'h11);
        rst = 1'b0;
        send(8'h22);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_write", 32'(write), 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_done", 32'(load_done), 32'd0);
        rst = 1'b1;
        nwr = 0;
        send(8'h33);
        if (write) nwr++;
        send(8'h44);
        if (write) nwr++;
        send(8'h55);
        if (write) nwr++;
        rx_valid = 1'b0;
        @(negedge clk);
        if (write) nwr++;
        chk("mid_after_writes", 32'(nwr), 32'd0);
        chk("mid_after_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_after_done", 32'(load_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program memory's load port: receives a framed byte stream from a serial receiver (valid/ready) and drives progmem `write`/`writeaddr`/`writevalue` to fill program memory at run time.
- Holds the CPU in reset while loading. Releases it only after a complete, validated image has been written.
- Sits between the UART receiver and progmem/cpu at top level.
- Replaces `$readmemh` preloading on hardware.

Parameters:
- SIZE, 256, program memory depth in bytes; maximum accepted image length.
- ADDR_W, 8, width of `writeaddr`; must satisfy 2^ADDR_W >= SIZE.
- BASE_ADDR, 0, address of first payload byte.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rx_valid  in  1  byte available from receiver
- rx_data  in  8  received byte
- rx_ready  out  1  loader can accept a byte
- write  out  1  one-cycle progmem write strobe
- writeaddr  out  ADDR_W  progmem write address
- writevalue  out  8  progmem write data
- cpu_rst  out  1  active-high reset to cpu; asserted while no valid image is loaded
- load_done  out  1  level: last frame completed successfully
- load_err  out  1  level: last frame aborted

Behaviour:
- Reset is synchronous and active-low: `rst`==0 sampled at a `clk` edge resets the block.
- Reset values:
  - `rx_ready`=0, `write`=0, `writeaddr`=0, `writevalue`=0.
  - `cpu_rst`=1, `load_done`=0, `load_err`=0.
  - State IDLE; length, index and checksum registers cleared.
- `rx_ready`=1 in every cycle after reset release. The block never back-pressures.
- A byte is accepted on a `clk` edge where `rx_valid` && `rx_ready`. Non-accepted cycles change no state.
- Frame format: SYNC, LEN_HI, LEN_LO, LEN payload bytes, then a checksum byte (only with the optional feature).
- FSM states and transitions:
  - IDLE: accept SYNC -> LEN_HI. Any other byte is discarded; stay in IDLE.
  - LEN_HI: store byte as len[15:8] -> LEN_LO.
  - LEN_LO: store len[7:0]. Full 16-bit LEN==0 or LEN>SIZE -> ERR; otherwise -> DATA with idx=0, csum=0.
  - DATA: each accepted byte b issues a write. Registered outputs on the next edge: `write`=1, `writeaddr`=(BASE_ADDR+idx) mod 2^ADDR_W, `writevalue`=b. Then idx++ and csum+=b (mod 256). When idx reaches LEN-1 on accept -> CSUM (feature on) or DONE (feature off).
  - CSUM: see Optional Feature.
  - DONE: `load_done`=1, `load_err`=0. Accepting SYNC restarts -> LEN_HI; other bytes are ignored.
  - ERR: `load_err`=1, `load_done`=0. Accepting SYNC -> LEN_HI; other bytes are ignored.
- `write` is high for exactly one cycle per payload byte. Consecutive accepts produce back-to-back writes.
- `cpu_rst` timing:
  - Deasserts on the edge after DONE is entered, which is after the final `write` pulse has been presented.
  - Reasserts on the same edge that accepts a SYNC in DONE or ERR, i.e. upon entering LEN_HI.
  - Never deasserts from ERR.
- `load_done` and `load_err` clear when LEN_HI is entered.
- Reset mid-frame: returns to IDLE immediately. Any partial image is left in progmem. `cpu_rst`=1.
- BASE_ADDR+LEN beyond 2^ADDR_W wraps the address modulo 2^ADDR_W. No error is flagged.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Frame carries one trailing checksum byte.
  - In CSUM, the accepted byte is compared with csum, the 8-bit sum of all payload bytes.
  - Equal -> DONE. Unequal -> ERR, with `cpu_rst` held at 1.
  - No write is issued for the checksum byte.
- Undefined:
  - No CSUM state and no checksum register.
  - After the last payload byte the FSM goes directly to DONE.

Test Plan:
- Post-reset: hold `rst`=0 for 2 cycles, then release -> `rx_ready` rises the next cycle; `cpu_rst`=1, `write`=0, `load_done`=0.
- Nominal load, feature off:
  - Stimulus: A5 00 03 10 20 30.
  - Required: writes (0,10), (1,20), (2,30) on consecutive cycles following each accept; `load_done`=1; `cpu_rst` falls one cycle after the last write.
- Checksum, feature on:
  - A5 00 02 01 02 03 -> DONE, `cpu_rst`=0.
  - A5 00 02 01 02 04 -> ERR, `load_err`=1, `cpu_rst`=1, exactly 2 writes issued.
- Bad length:
  - A5 00 00 -> ERR, no write.
  - A5 01 01 (257 > SIZE) -> ERR.
  - A following A5 00 01 7F -> DONE, write (0,7F).
- Resync and gaps:
  - Garbage 00 FF 12 before A5; `rx_valid` gaps of 0–3 cycles between bytes.
  - Required: garbage ignored, writes identical to the gap-free run.
- Reload and reset mid-frame:
  - After DONE, send A5: `cpu_rst` reasserts that cycle.
  - Assert `rst`=0 during DATA after 1 of 3 bytes -> IDLE, `cpu_rst`=1, no further writes.
